mic_volume_meter: RTL and testbench

- Upstream feeder of the game FSM's 5-bit `volume` input.
- Converts raw 12-bit microphone ADC samples into a smoothed loudness level in the range 0..15.
- Rectifies each sample around mid-scale and takes the peak over a fixed window of samples.
- Maps the peak to a level, then applies instant-attack / one-step-decay smoothing so the on-screen bar and the recorder stage see stable values.

---
 rtl/mic_volume_meter_pkg.sv | 23 ++
 rtl/mic_peak_window.sv | 53 +++++
 rtl/mic_volume_meter.sv | 75 +++++++
 tb/tb_mic_volume_meter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mic_volume_meter_pkg.sv
// Shared microphone/game constants and the sample rectifier.
// The game FSM's volume bar and recorder also import this package.
package mic_volume_meter_pkg;
   localparam int ADC_W           = 12;
   localparam int VOL_W           = 5;
   localparam int LVL_W           = 4;
   localparam int VOL_MAX         = 15;
   localparam int RECT_W          = 11;
   localparam int RECT_MAX        = 2047;
   localparam int DEF_BASELINE    = 2048;
   localparam int DEF_NOISE_FLOOR = 128;

   typedef logic [ADC_W-1:0]  sample_t;
   typedef logic [RECT_W-1:0] rect_t;
   typedef logic [LVL_W-1:0]  level_t;

   // Distance from the silence code, clamped so a full-negative swing still fits 11 bits.
   function automatic rect_t rectify(input sample_t s, input sample_t base);
      sample_t d;
      d = (s >= base) ? sample_t'(s - base) : sample_t'(base - s);
      return (d > sample_t'(RECT_MAX)) ? rect_t'(RECT_MAX) : d[RECT_W-1:0];
   endfunction
endpackage

// File: rtl/mic_peak_window.sv
// Rectified running peak over a fixed count of valid samples.
// window_done/window_peak are combinational on the window's closing strobe.
module mic_peak_window
   import mic_volume_meter_pkg::*;
#(
   parameter int WINDOW   = 4000,
   parameter int BASELINE = DEF_BASELINE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [ADC_W-1:0] mic_sample,
   input  logic             sample_valid,
   output logic             window_done,
   output rect_t            window_peak
);
   localparam int               CNT_W = $clog2(WINDOW);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WINDOW - 1);
   localparam sample_t          BASE  = sample_t'(BASELINE);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   rect_t            max_q, max_d;
   rect_t            rect;

   always_comb begin
      rect        = rectify(mic_sample, BASE);
      window_peak = (rect > max_q) ? rect : max_q;
      window_done = sample_valid && (cnt_q == LAST);
   end

   always_comb begin
      cnt_d = cnt_q;
      max_d = max_q;
      if (sample_valid) begin
         if (window_done) begin
            cnt_d = '0;
            max_d = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
            max_d = window_peak;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         max_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         max_q <= max_d;
      end
   end
endmodule

// File: rtl/mic_volume_meter.sv
// Window peak -> 0..15 loudness level with instant attack and one-step decay.
// Outputs update once per window, one cycle after the closing sample.
module mic_volume_meter
   import mic_volume_meter_pkg::*;
#(
   parameter int WINDOW      = 4000,
   parameter int BASELINE    = DEF_BASELINE,
   parameter int NOISE_FLOOR = DEF_NOISE_FLOOR,
   parameter int LEVEL_SHIFT = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [ADC_W-1:0] mic_sample,
   input  logic             sample_valid,
   output logic [VOL_W-1:0] volume,
   output logic             volume_valid,
   output logic [ADC_W-1:0] peak
);
   logic   window_done;
   rect_t  window_peak;
   rect_t  shifted;
   level_t raw;
   level_t vol_q, vol_d;
   rect_t  peak_q, peak_d;
   logic   valid_q, valid_d;

   mic_peak_window #(
      .WINDOW   (WINDOW),
      .BASELINE (BASELINE)
   ) u_peak (
      .clk          (clk),
      .rst          (rst),
      .mic_sample   (mic_sample),
      .sample_valid (sample_valid),
      .window_done  (window_done),
      .window_peak  (window_peak)
   );

   always_comb begin
      shifted = window_peak >> LEVEL_SHIFT;
      if (window_peak < rect_t'(NOISE_FLOOR))
         raw = '0;
      else if (shifted > rect_t'(VOL_MAX))
         raw = level_t'(VOL_MAX);
      else
         raw = shifted[LVL_W-1:0];
   end

   // raw >= 0 guarantees vol_q > 0 whenever the decay branch is taken.
   always_comb begin
      valid_d = window_done;
      peak_d  = peak_q;
      vol_d   = vol_q;
      if (window_done) begin
         peak_d = window_peak;
         vol_d  = (raw >= vol_q) ? raw : level_t'(vol_q - 1'b1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vol_q   <= '0;
         peak_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         vol_q   <= vol_d;
         peak_q  <= peak_d;
         valid_q <= valid_d;
      end
   end

   assign volume       = {{(VOL_W - LVL_W){1'b0}}, vol_q};
   assign peak         = {{(ADC_W - RECT_W){1'b0}}, peak_q};
   assign volume_valid = valid_q;
endmodule

// File: tb/tb_mic_volume_meter.sv
// Scoreboard bench: a window-level reference model queues expected results,
// a negedge monitor checks each volume_valid pulse against the queue.
module tb_mic_volume_meter;
   localparam int WIN = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [11:0] mic_sample = '0;
   logic        sample_valid = 1'b0;
   logic [4:0]  volume;
   logic        volume_valid;
   logic [11:0] peak;

   typedef struct {
      int pk;
      int vol;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   win_n = 0;

   // reference model state
   int m_cnt = 0;
   int m_max = 0;
   int m_vol = 0;

   always #5 clk = ~clk;

   mic_volume_meter #(
      .WINDOW      (WIN),
      .BASELINE    (2048),
      .NOISE_FLOOR (128),
      .LEVEL_SHIFT (7)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .mic_sample   (mic_sample),
      .sample_valid (sample_valid),
      .volume       (volume),
      .volume_valid (volume_valid),
      .peak         (peak)
   );

   task automatic check(input string name, input int act, input int want);
      total++;
      if (act != want) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, want);
      end
   endtask

   function automatic int rect_of(input int s);
      int d;
      d = s - 2048;
      if (d < 0) d = -d;
      if (d > 2047) d = 2047;
      return d;
   endfunction

   // Window-level model: max of rectified samples, level map, attack/decay.
   task automatic model_accept(input int s);
      int r, raw;
      r = rect_of(s);
      if (r > m_max) m_max = r;
      m_cnt++;
      if (m_cnt == WIN) begin
         if (m_max < 128) raw = 0;
         else raw = m_max / 128;
         if (raw > 15) raw = 15;
         if (raw >= m_vol) m_vol = raw;
         else m_vol = m_vol - 1;
         exp_q.push_back('{pk: m_max, vol: m_vol});
         m_cnt = 0;
         m_max = 0;
      end
   endtask

   task automatic strobe(input int s, input int gap);
      repeat (gap) begin
         @(negedge clk);
         sample_valid = 1'b0;
         mic_sample   = 12'($urandom_range(0, 4095));
      end
      @(negedge clk);
      sample_valid = 1'b1;
      mic_sample   = 12'(s);
      model_accept(s);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         sample_valid = 1'b0;
         mic_sample   = 12'($urandom_range(0, 4095));
      end
   endtask

   task automatic do_reset(input bit with_strobe, input int s);
      @(negedge clk);
      rst          = 1'b1;
      sample_valid = with_strobe;
      mic_sample   = 12'(s);
      m_cnt = 0;
      m_max = 0;
      m_vol = 0;
      @(negedge clk);
      rst          = 1'b0;
      sample_valid = 1'b0;
      check("reset_volume", int'(volume), 0);
      check("reset_peak", int'(peak), 0);
      check("reset_valid", int'(volume_valid), 0);
   endtask

   // window of WIN samples: `fill` everywhere except `special` at position pos
   task automatic window(input int fill, input int special, input int pos, input int gap);
      for (int i = 0; i < WIN; i++)
         strobe((i == pos) ? special : fill, gap);
      idle(2);
   endtask

   // monitor
   always @(negedge clk) begin
      if (!rst && volume_valid) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_valid: volume_valid=1 with no window closed (volume=%0d peak=%0d)",
                     volume, peak);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            win_n++;
            $display("window %0d: peak=%0d volume=%0d (expected peak=%0d volume=%0d)",
                     win_n, peak, volume, e.pk, e.vol);
            check("peak", int'(peak), e.pk);
            check("volume", int'(volume), e.vol);
            check("volume_bit4", int'(volume[4]), 0);
         end
      end
   end

   initial begin
      do_reset(1'b0, 0);
      // silence
      window(2048, 2048, 0, 0);
      // loud positive, then full negative (clamped)
      window(2048, 4095, 7, 0);
      window(2048, 0, 3, 0);
      // decay 14..11
      repeat (4) window(2048, 2048, 0, 0);
      // raw 8 below volume 11 -> decay to 10, then attack to 14
      window(2048, 3072, 2, 0);
      window(2048, 3840, 5, 0);
      // noise floor boundary from reset state
      do_reset(1'b0, 0);
      window(2048, 2148, 4, 0);
      window(2048, 2176, 6, 0);
      // strobe gaps with junk on idle cycles
      window(2048, 3500, 1, 5);
      for (int w = 0; w < 3; w++) begin
         for (int i = 0; i < WIN; i++) strobe(2048, int'($urandom_range(0, 5)));
         idle(2);
      end
      // reset mid-window, coinciding with a strobe
      for (int i = 0; i < 5; i++) strobe(4095, 0);
      do_reset(1'b1, 4095);
      window(2048, 2048, 0, 0);
      // randomized windows with varying amplitude
      for (int w = 0; w < 40; w++) begin
         int amp;
         amp = int'($urandom_range(0, 2100));
         for (int i = 0; i < WIN; i++) begin
            int s;
            s = 2048 + int'($urandom_range(0, 2 * amp)) - amp;
            if (s < 0) s = 0;
            if (s > 4095) s = 4095;
            strobe(s, int'($urandom_range(0, 2)));
         end
      end
      idle(4);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
